mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mips_pkg.sv | 13 +
 rtl/arb_timer.sv | 25 ++
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared arbiter types: state encoding for mem_port_arbiter and the read data
// returned to a requester whose access was aborted.
package mips_pkg;

   typedef logic [1:0] arb_state_t;

   localparam arb_state_t IDLE     = 2'd0;
   localparam arb_state_t SERVE_IF = 2'd1;
   localparam arb_state_t SERVE_DM = 2'd2;

   localparam logic [31:0] ARB_ERR_RDATA = 32'h0;

endpackage

// File: rtl/arb_timer.sv
// Wait counter for an outstanding memory access: cleared on grant, advanced on
// every serving cycle without mem_ack, expiring on the ACK_TIMEOUT-th such cycle.
module arb_timer #(
   parameter int ACK_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic inc,
   output logic expired
);

   logic [7:0] wait_cnt;

   // Expiry is flagged during the last permitted wait cycle so the abort lands on that edge.
   assign expired = inc && (wait_cnt == 8'(ACK_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst || clear)
         wait_cnt <= '0;
      else if (inc)
         wait_cnt <= wait_cnt + 8'd1;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (instruction fetch / data memory) arbiter for one shared memory port.
// Define STARVE_GUARD_EN to force an IF grant after three consecutive DM grants.
module mem_port_arbiter
   import mips_pkg::*;
#(
   parameter int ACK_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ready,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic [31:0] dm_rdata,
   output logic        dm_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        stall,
   output logic        err
);

   arb_state_t  state;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic        lat_we;
   logic        serving;
   logic        arb_open;
   logic        grant_if;
   logic        grant_dm;
   logic        ack_done;
   logic        expired;
   logic        finish;

   assign serving  = (state == SERVE_IF) || (state == SERVE_DM);
   // A completion's ready cycle is never an arbitration cycle, so every grant is
   // preceded by a quiet IDLE cycle and a just-finished request cannot be re-granted.
   assign arb_open = (state == IDLE) && !if_ready && !dm_ready;
   assign ack_done = serving && mem_ack;
   assign finish   = ack_done || expired;

`ifdef STARVE_GUARD_EN
   logic [1:0] starve_cnt;
   logic       favor_if;

   assign favor_if = (starve_cnt == 2'd3) && if_req;
   assign grant_dm = arb_open && dm_req && !favor_if;
   assign grant_if = arb_open && if_req && !grant_dm;

   always_ff @(posedge clk) begin
      if (rst || grant_if)
         starve_cnt <= 2'd0;
      else if (grant_dm)
         starve_cnt <= !if_req ? 2'd0 : (starve_cnt == 2'd3) ? 2'd3 : starve_cnt + 2'd1;
   end
`else
   assign grant_dm = arb_open && dm_req;
   assign grant_if = arb_open && if_req && !dm_req;
`endif

   arb_timer #(
      .ACK_TIMEOUT(ACK_TIMEOUT)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clear  (grant_if || grant_dm),
      .inc    (serving && !mem_ack),
      .expired(expired)
   );

   assign mem_req   = serving;
   assign mem_we    = serving && lat_we;
   assign mem_addr  = lat_addr;
   assign mem_wdata = lat_wdata;
   assign stall     = (if_req && !if_ready) || (dm_req && !dm_ready);

   // Operands are captured at grant; later changes on the requester bus are ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_we    <= 1'b0;
         if_ready  <= 1'b0;
         dm_ready  <= 1'b0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
         err       <= 1'b0;
      end else begin
         if_ready <= 1'b0;
         dm_ready <= 1'b0;
         if (expired)
            err <= 1'b1;
         case (state)
            IDLE: begin
               if (grant_dm) begin
                  state     <= SERVE_DM;
                  lat_addr  <= dm_addr;
                  lat_we    <= dm_we;
                  lat_wdata <= dm_wdata;
               end else if (grant_if) begin
                  state     <= SERVE_IF;
                  lat_addr  <= if_addr;
                  lat_we    <= 1'b0;
                  lat_wdata <= '0;
               end
            end
            SERVE_IF: begin
               if (finish) begin
                  state    <= IDLE;
                  if_ready <= 1'b1;
                  if_rdata <= ack_done ? mem_rdata : ARB_ERR_RDATA;
               end
            end
            SERVE_DM: begin
               if (finish) begin
                  state    <= IDLE;
                  dm_ready <= 1'b1;
                  dm_rdata <= (ack_done && !lat_we) ? mem_rdata : ARB_ERR_RDATA;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a timestamp-based transaction model predicts
// grants, memory-bus contents, ready pulses, read data, err and stall every cycle.
module tb_mem_port_arbiter;

   localparam int ACK_TIMEOUT = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, dm_req, dm_we, mem_ack;
   logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
   logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
   logic        if_ready, dm_ready, mem_req, mem_we, stall, err;

   int errors = 0;
   int checks = 0;

   // model state
   int          cyc, start_c, end_c, ack_c, free_from;
   bit          busy, who_dm, timed_out, if_pend, dm_pend, exp_err;
   logic [31:0] g_addr, g_wdata, ack_rdata, exp_if_rdata, exp_dm_rdata;
   logic        g_we;
`ifdef STARVE_GUARD_EN
   int          starve;
`endif

   // stimulus knobs
   int          plan_k, p_if, p_dm;
   bit          noise, force_if, force_dm, force_dm_we, force_rdata_en;
   logic [31:0] force_if_addr, force_dm_addr, force_dm_wdata, force_rdata;

   mem_port_arbiter #(.ACK_TIMEOUT(ACK_TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_ready(dm_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .stall(stall), .err(err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, obs, exp);
      end
   endtask

   // Holds reset for n cycles (with a spurious ack present) and checks every reset value.
   task automatic doReset(input int n);
      rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b1;
      repeat (n) begin
         @(posedge clk); #1; cyc++;
         checkOutput("rst_mem_req", mem_req, 0);
         checkOutput("rst_mem_we", mem_we, 0);
         checkOutput("rst_mem_addr", mem_addr, 0);
         checkOutput("rst_mem_wdata", mem_wdata, 0);
         checkOutput("rst_if_ready", if_ready, 0);
         checkOutput("rst_dm_ready", dm_ready, 0);
         checkOutput("rst_if_rdata", if_rdata, 0);
         checkOutput("rst_dm_rdata", dm_rdata, 0);
         checkOutput("rst_err", err, 0);
      end
      rst = 1'b0; mem_ack = 1'b0;
      busy = 0; if_pend = 0; dm_pend = 0; exp_err = 0;
      exp_if_rdata = '0; exp_dm_rdata = '0;
      free_from = cyc;
`ifdef STARVE_GUARD_EN
      starve = 0;
`endif
   endtask

   // One clock cycle: compare against the model, then drive this cycle's inputs.
   task automatic applyStimulus();
      bit in_svc, done, exp_ifr, exp_dmr, chose_dm;
      @(posedge clk); #1; cyc++;
      in_svc  = busy && cyc >= start_c && cyc < end_c;
      done    = busy && cyc == end_c;
      exp_ifr = done && !who_dm;
      exp_dmr = done && who_dm;
      if (done) begin
         if (who_dm) exp_dm_rdata = (timed_out || g_we) ? 32'h0 : ack_rdata;
         else        exp_if_rdata = timed_out ? 32'h0 : ack_rdata;
         if (timed_out) exp_err = 1;
      end
      checkOutput("mem_req", mem_req, in_svc);
      checkOutput("if_ready", if_ready, exp_ifr);
      checkOutput("dm_ready", dm_ready, exp_dmr);
      checkOutput("if_rdata", if_rdata, exp_if_rdata);
      checkOutput("dm_rdata", dm_rdata, exp_dm_rdata);
      checkOutput("err", err, exp_err);
      if (in_svc) begin
         checkOutput("mem_addr", mem_addr, g_addr);
         checkOutput("mem_we", mem_we, g_we);
         if (g_we) checkOutput("mem_wdata", mem_wdata, g_wdata);
      end
      if (done) begin
         busy = 0;
         free_from = cyc + 1;
         if (who_dm) begin dm_pend = 0; dm_req = 0; end
         else        begin if_pend = 0; if_req = 0; end
      end
      // granted requester scrambles its operands; the arbiter must have latched them
      if (busy && cyc >= start_c) begin
         if (who_dm) begin dm_addr = $urandom; dm_wdata = $urandom; dm_we = 1'($urandom_range(1)); end
         else if_addr = $urandom;
      end
      if (!if_pend && !(done && !who_dm)) begin
         if (force_if) begin if_pend = 1; if_addr = force_if_addr; end
         else if ($urandom_range(99) < p_if) begin if_pend = 1; if_addr = $urandom & 32'hFFFF_FFFC; end
         if_req = if_pend;
      end
      if (!dm_pend && !(done && who_dm)) begin
         if (force_dm) begin
            dm_pend = 1; dm_we = force_dm_we; dm_addr = force_dm_addr; dm_wdata = force_dm_wdata;
         end else if ($urandom_range(99) < p_dm) begin
            dm_pend = 1; dm_we = 1'($urandom_range(1));
            dm_addr = $urandom & 32'hFFFF_FFFC; dm_wdata = $urandom;
         end
         dm_req = dm_pend;
      end
      force_if = 0; force_dm = 0;
      if (!busy && cyc >= free_from && (if_pend || dm_pend)) begin
         chose_dm = dm_pend;
`ifdef STARVE_GUARD_EN
         if (starve == 3 && if_pend) chose_dm = 0;
         if (chose_dm) starve = if_pend ? ((starve == 3) ? 3 : starve + 1) : 0;
         else          starve = 0;
`endif
         who_dm  = chose_dm;
         busy    = 1;
         start_c = cyc + 1;
         g_addr  = chose_dm ? dm_addr : if_addr;
         g_we    = chose_dm ? dm_we : 1'b0;
         g_wdata = dm_wdata;
         if (plan_k == -2 || (plan_k == -1 && $urandom_range(15) == 0)) begin
            timed_out = 1; ack_c = -1; end_c = start_c + ACK_TIMEOUT;
         end else begin
            timed_out = 0;
            ack_c = start_c + ((plan_k >= 0) ? plan_k : int'($urandom_range(4)));
            end_c = ack_c + 1;
         end
      end
      mem_rdata = $urandom;
      if (busy && cyc == ack_c) begin
         mem_ack = 1'b1;
         if (force_rdata_en) mem_rdata = force_rdata;
         ack_rdata = mem_rdata;
      end else begin
         mem_ack = noise && !(busy && cyc >= start_c) && ($urandom_range(3) == 0);
      end
      #1;
      checkOutput("stall", stall, (if_req & ~exp_ifr) | (dm_req & ~exp_dmr));
   endtask

   initial begin
      rst = 1'b1; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
      mem_rdata = 0; mem_ack = 0;
      cyc = 0; plan_k = -1; p_if = 0; p_dm = 0; noise = 0;
      force_if = 0; force_dm = 0; force_dm_we = 0; force_rdata_en = 0;
      force_if_addr = 0; force_dm_addr = 0; force_dm_wdata = 0; force_rdata = 0;
      ack_rdata = 0; g_addr = 0; g_wdata = 0; g_we = 0; timed_out = 0; who_dm = 0;
      start_c = 0; end_c = 0; ack_c = -1;
      doReset(2);

      $display("[TB] instruction fetch, ack two cycles after mem_req");
      force_if = 1; force_if_addr = 32'h40; plan_k = 2;
      force_rdata_en = 1; force_rdata = 32'h8C02_0004;
      repeat (6) applyStimulus();
      checkOutput("fetch_if_rdata", if_rdata, 32'h8C02_0004);
      force_rdata_en = 0;

      $display("[TB] simultaneous IF and DM store, immediate ack");
      force_if = 1; force_if_addr = 32'h200;
      force_dm = 1; force_dm_we = 1; force_dm_addr = 32'h100; force_dm_wdata = 32'h55;
      plan_k = 0;
      repeat (10) applyStimulus();

      $display("[TB] DM load then DM load that times out");
      force_dm = 1; force_dm_we = 0; force_dm_addr = 32'h180; plan_k = 1;
      repeat (5) applyStimulus();
      force_dm = 1; force_dm_we = 0; force_dm_addr = 32'h300; plan_k = -2;
      repeat (22) applyStimulus();
      checkOutput("timeout_err_sticky", err, 1);

      $display("[TB] reset during a DM store");
      force_dm = 1; force_dm_we = 1; force_dm_addr = 32'h104; force_dm_wdata = 32'hAA; plan_k = 10;
      repeat (3) applyStimulus();
      doReset(1);
      repeat (4) applyStimulus();

      $display("[TB] random traffic");
      plan_k = -1; p_if = 35; p_dm = 35; noise = 1;
      repeat (600) applyStimulus();
      p_if = 0; p_dm = 0; noise = 0;
      repeat (60) applyStimulus();

      $display("[TB] both requesters held busy");
      plan_k = 0; p_if = 100; p_dm = 100;
      repeat (60) applyStimulus();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
